uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, meaning number of packet requesters (2..8).
REQ-002 Parameter ID_W, default 3, meaning width of grant_id.
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  NUM_REQ  per-requester byte valid.
REQ-006 req_data  input  8*NUM_REQ  per-requester byte; requester i in bits [8i+7:8i].
REQ-007 req_last  input  NUM_REQ  marks the final byte of the packet.
REQ-008 req_ready  output  NUM_REQ  one-hot byte-accept strobe to the granted requester.
REQ-009 tx_start  output  1  one-cycle start pulse to uart_tx.
REQ-010 tx_data  output  8  byte to uart_tx (send_data).
REQ-011 tx_ready  input  1  uart_tx idle flag: high in IDLE, low from START through STOP.
REQ-012 busy  output  1  high while a packet is owned.
REQ-013 grant_id  output  ID_W  index of the current owner; valid while busy.

Function
REQ-014 The FSM SHALL have the states IDLE, ARB, LOAD, START, WAIT_BUSY, WAIT_DONE and CSUM.
REQ-015 IDLE->ARB when any req_valid=1 and tx_ready=1.
REQ-016 ARB: round-robin pick, starting one above the last granted index (wrapping NUM_REQ-1->0); latch grant_id; set busy=1; go to LOAD.
REQ-017 LOAD: when req_valid[grant_id]=1, pulse req_ready[grant_id] for one cycle; capture the byte into tx_data and req_last into last_r; XOR the byte into csum_r; go to START.
REQ-018 LOAD with req_valid[grant_id]=0: hold in LOAD with no timeout; ownership is kept.
REQ-019 START: tx_start=1 for exactly one cycle; go to WAIT_BUSY.
REQ-020 WAIT_BUSY: wait for tx_ready=0, then go to WAIT_DONE; this guards the one-cycle lag of uart_tx leaving IDLE.
REQ-021 WAIT_DONE: wait for tx_ready=1.
REQ-022 WAIT_DONE exit: if last_r=0, go to LOAD; otherwise go to CSUM, or to IDLE when checksum is disabled.
REQ-023 tx_data SHALL remain stable from START until leaving WAIT_DONE, because uart_tx samples send_data bit-by-bit.
REQ-024 Bytes from non-granted requesters SHALL never be accepted; their req_ready SHALL stay 0.
REQ-025 Returning to IDLE SHALL clear busy and csum_r and update the round-robin pointer.
REQ-026 Requests arriving mid-packet are held off; the next ARB serves them in round-robin order.
REQ-027 Throughput: at most one byte in flight; no tx_start while tx_ready=0.

Reset
REQ-028 On rst=1 at a clock edge, the outputs SHALL be: state=IDLE, tx_start=0, tx_data=8'h00, req_ready=0, busy=0, grant_id=0, csum_r=0, and RR pointer=NUM_REQ-1 so that requester 0 wins first.
REQ-029 Reset mid-packet SHALL abandon the packet immediately; no further tx_start is issued.
REQ-030 An in-flight uart_tx byte completes on its own; after reset the FSM first waits for tx_ready=1 in IDLE before arbitrating (see REQ-015).

Configuration
REQ-031 The macro UART_ARB_CHECKSUM_EN SHALL control the checksum byte.
REQ-032 With UART_ARB_CHECKSUM_EN defined: after the last byte's WAIT_DONE, CSUM loads tx_data=csum_r (XOR of all packet bytes) and re-enters START; its WAIT_DONE returns to IDLE.
REQ-033 Without UART_ARB_CHECKSUM_EN: the CSUM state and csum_r are absent; the wire packet equals the requester bytes exactly.

Structure
REQ-034 Package uart_arb_pkg SHALL hold the FSM state enum and a default NUM_REQ constant.
REQ-035 Sub-module rr_arbiter SHALL be combinational round-robin select: pointer + request vector -> one-hot grant + index.
REQ-036 The block instantiates no uart_tx; it connects to one externally.

Verification (bench: uart_tx with BPS=4, UART line decoded by monitor)
REQ-037 Single requester 0 sends 3 bytes 8'hA5, 8'h3C, 8'h01 (last on 8'h01) -> line carries A5,3C,01 in order; with CHECKSUM_EN a fourth byte 8'h98 follows; busy falls after the final stop bit.
REQ-038 Requesters 0 and 1 both valid at the first cycle after reset, 1-byte packets 8'h11 and 8'h22 -> 11 is sent first, then 22; grant_id goes 0 then 1.
REQ-039 Requester 1 valid continuously while requester 0 is mid-packet -> no req_ready[1] until requester 0's last byte (and checksum) completes.
REQ-040 Stall: requester 0 drops req_valid for 50 cycles between bytes -> FSM holds in LOAD, busy=1, tx_start=0 throughout, then resumes.
REQ-041 tx_ready held low by the bench for 10 cycles after tx_start -> exactly one tx_start per byte; tx_data is unchanged until tx_ready returns high.
REQ-042 rst pulsed during the second byte's WAIT_DONE -> outputs return to the REQ-028 values next cycle; no further tx_start until tx_ready=1 and a new request arrives.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART TX packet arbiter.
// UART_ARB_CHECKSUM_EN adds the CSUM state used for the trailing XOR byte.
package uart_arb_pkg;

  localparam int DEFAULT_NUM_REQ = 2;
  localparam int DEFAULT_ID_W    = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARB       = 3'd1,
    LOAD      = 3'd2,
    START     = 3'd3,
    WAIT_BUSY = 3'd4,
    WAIT_DONE = 3'd5
`ifdef UART_ARB_CHECKSUM_EN
    ,
    CSUM      = 3'd6
`endif
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: the search starts one above ptr and wraps,
// returning a one-hot grant, its index and whether anything was requesting.
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int ID_W    = DEFAULT_ID_W
) (
  input  logic [ID_W-1:0]    ptr,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_req
);

  always_comb begin
    int cand;
    cand      = 0;
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(ptr) + off) % NUM_REQ;
      if (!any_req && req[cand]) begin
        any_req     = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet arbiter feeding one external uart_tx: a requester owns the line for a whole packet.
// Define UART_ARB_CHECKSUM_EN to append an XOR checksum byte after every packet.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int ID_W    = DEFAULT_ID_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id
);

  arb_state_t         state;
  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] owner_mask;
  logic               last_r;
`ifdef UART_ARB_CHECKSUM_EN
  logic [7:0]         csum_r;
  logic               csum_phase;
`endif

  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_any;

  logic               sel_valid;
  logic [7:0]         sel_data;
  logic               sel_last;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .ptr       (rr_ptr),
    .req       (req_valid),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  // Owner's byte lane, chosen by the one-hot mask latched at arbitration time.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = 8'h00;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_mask[i]) begin
        sel_valid = req_valid[i];
        sel_data  = req_data[8*i +: 8];
        sel_last  = req_last[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      req_ready  <= '0;
      busy       <= 1'b0;
      grant_id   <= '0;
      owner_mask <= '0;
      last_r     <= 1'b0;
      rr_ptr     <= ID_W'(NUM_REQ - 1);
`ifdef UART_ARB_CHECKSUM_EN
      csum_r     <= 8'h00;
      csum_phase <= 1'b0;
`endif
    end else begin
      tx_start  <= 1'b0;
      req_ready <= '0;
      unique case (state)
        IDLE: begin
          if (|req_valid && tx_ready) state <= ARB;
        end
        ARB: begin
          if (arb_any) begin
            grant_id   <= arb_idx;
            owner_mask <= arb_grant;
            busy       <= 1'b1;
            state      <= LOAD;
          end else begin
            state <= IDLE;
          end
        end
        LOAD: begin
          if (sel_valid) begin
            req_ready <= owner_mask;
            tx_data   <= sel_data;
            last_r    <= sel_last;
            tx_start  <= 1'b1;
`ifdef UART_ARB_CHECKSUM_EN
            csum_r    <= csum_r ^ sel_data;
`endif
            state     <= START;
          end
        end
        START: begin
          state <= WAIT_BUSY;
        end
        // uart_tx drops tx_ready one cycle after the start pulse; do not mistake the old idle for done.
        WAIT_BUSY: begin
          if (!tx_ready) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_ready) begin
            if (!last_r) begin
              state <= LOAD;
            end
`ifdef UART_ARB_CHECKSUM_EN
            else if (!csum_phase) begin
              state <= CSUM;
            end
`endif
            else begin
              state      <= IDLE;
              busy       <= 1'b0;
              rr_ptr     <= grant_id;
              owner_mask <= '0;
`ifdef UART_ARB_CHECKSUM_EN
              csum_r     <= 8'h00;
              csum_phase <= 1'b0;
`endif
            end
          end
        end
`ifdef UART_ARB_CHECKSUM_EN
        CSUM: begin
          tx_data    <= csum_r;
          csum_phase <= 1'b1;
          tx_start   <= 1'b1;
          state      <= START;
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx (BPS=4) that samples tx_data bit by bit.
// Expectations adapt to UART_ARB_CHECKSUM_EN when the bundle is built with it.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 3;
  localparam int BPS     = 4;
`ifdef UART_ARB_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_ready;
  logic                 busy;
  logic [ID_W-1:0]      grant_id;

  int compared   = 0;
  int mismatched = 0;

  logic [8:0]      q0[$];
  logic [8:0]      q1[$];
  logic [7:0]      line_q[$];
  logic [7:0]      exp_q[$];
  logic [ID_W-1:0] grant_q[$];
  bit              stall0   = 1'b0;
  bit              check_en = 1'b1;
  int              hold_extra  = 0;
  int              start_cnt   = 0;
  int              overlap_err = 0;
  int              stab_err    = 0;
  int              cross_err   = 0;
  int              early_err   = 0;

  uart_tx_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Requesters: present the queue head, pop it when req_ready is seen.
  initial begin
    logic [8:0] tmp;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      if (req_ready[0] && q0.size() > 0) tmp = q0.pop_front();
      if (req_ready[1] && q1.size() > 0) tmp = q1.pop_front();
      if (q0.size() > 0) begin
        tmp = q0[0];
        req_valid[0]   = !stall0;
        req_data[7:0]  = tmp[7:0];
        req_last[0]    = tmp[8];
      end else begin
        req_valid[0]   = 1'b0;
        req_data[7:0]  = 8'h00;
        req_last[0]    = 1'b0;
      end
      if (q1.size() > 0) begin
        tmp = q1[0];
        req_valid[1]   = 1'b1;
        req_data[15:8] = tmp[7:0];
        req_last[1]    = tmp[8];
      end else begin
        req_valid[1]   = 1'b0;
        req_data[15:8] = 8'h00;
        req_last[1]    = 1'b0;
      end
    end
  end

  // uart_tx model: start + 8 data + stop bits of BPS cycles, data sampled mid-bit.
  initial begin
    bit         in_frame;
    bit         busy_prev;
    int         fcnt;
    int         bi;
    logic [7:0] ref_byte;
    logic [7:0] rx_byte;
    in_frame  = 1'b0;
    busy_prev = 1'b0;
    fcnt      = 0;
    ref_byte  = 8'h00;
    rx_byte   = 8'h00;
    tx_ready  = 1'b1;
    forever begin
      @(negedge clk);
      if (busy && !busy_prev) grant_q.push_back(grant_id);
      if (check_en && busy_prev && !busy && in_frame) early_err++;
      busy_prev = busy;
      for (int i = 0; i < NUM_REQ; i++)
        if (req_ready[i] && (!busy || int'(grant_id) != i)) cross_err++;
      if (tx_start) begin
        start_cnt++;
        if (!tx_ready || in_frame) overlap_err++;
      end
      if (in_frame) begin
        if (check_en && tx_data !== ref_byte) stab_err++;
        fcnt++;
        if (fcnt >= BPS + BPS/2 && fcnt <= 9*BPS && ((fcnt - BPS - BPS/2) % BPS) == 0) begin
          bi = (fcnt - BPS - BPS/2) / BPS;
          rx_byte[bi] = tx_data[bi];
        end
        if (fcnt >= 10*BPS + hold_extra) begin
          in_frame = 1'b0;
          tx_ready = 1'b1;
          line_q.push_back(rx_byte);
        end
      end else if (tx_start) begin
        in_frame = 1'b1;
        fcnt     = 0;
        ref_byte = tx_data;
        tx_ready = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int who, input logic [7:0] data, input logic last);
    if (who == 0) q0.push_back({last, data});
    else          q1.push_back({last, data});
  endtask

  task automatic waitLine(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (!(line_q.size() >= n && !busy && tx_ready) && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput({tag, "_done"}, 32'(k < budget), 32'd1);
  endtask

  task automatic checkLine(input string tag);
    logic [7:0] got;
    logic [7:0] want;
    checkOutput({tag, "_len"}, line_q.size(), exp_q.size());
    while (exp_q.size() > 0 && line_q.size() > 0) begin
      got  = line_q.pop_front();
      want = exp_q.pop_front();
      checkOutput({tag, "_byte"}, 32'(got), 32'(want));
    end
    line_q.delete();
    exp_q.delete();
  endtask

  task automatic checkGrants(input string tag, input int n, input logic [ID_W-1:0] g0, input logic [ID_W-1:0] g1);
    logic [ID_W-1:0] g;
    checkOutput({tag, "_ngrant"}, grant_q.size(), n);
    g = (grant_q.size() > 0) ? grant_q[0] : '1;
    checkOutput({tag, "_grant0"}, 32'(g), 32'(g0));
    if (n > 1) begin
      g = (grant_q.size() > 1) ? grant_q[1] : '1;
      checkOutput({tag, "_grant1"}, 32'(g), 32'(g1));
    end
    grant_q.delete();
  endtask

  initial begin
    int s;
    int s1;
    int n;
    int k;
    int win_starts;
    int win_rdy;
    int win_idle;

    // Reset values while rst is held.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy",      32'(busy),      32'd0);
    checkOutput("rst_tx_start",  32'(tx_start),  32'd0);
    checkOutput("rst_tx_data",   32'(tx_data),   32'h00);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_grant_id",  32'(grant_id),  32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single requester, three-byte packet.
    grant_q.delete();
    s = start_cnt;
    applyStimulus(0, 8'hA5, 1'b0);
    applyStimulus(0, 8'h3C, 1'b0);
    applyStimulus(0, 8'h01, 1'b1);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h01);
    if (CSUM_ON) exp_q.push_back(8'h98);
    n = exp_q.size();
    waitLine(n, 1000, "t1");
    checkLine("t1");
    checkOutput("t1_starts", start_cnt - s, n);
    checkOutput("t1_early_busy_drop", early_err, 0);
    checkGrants("t1", 1, 3'd0, 3'd0);

    // Both requesters valid at the first cycle after reset.
    rst = 1'b1;
    applyStimulus(0, 8'h11, 1'b1);
    applyStimulus(1, 8'h22, 1'b1);
    repeat (2) @(negedge clk);
    grant_q.delete();
    rst = 1'b0;
    exp_q.push_back(8'h11);
    if (CSUM_ON) exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    if (CSUM_ON) exp_q.push_back(8'h22);
    n = exp_q.size();
    waitLine(n, 1000, "t2");
    checkLine("t2");
    checkGrants("t2", 2, 3'd0, 3'd1);

    // Requester 1 waits out requester 0's whole packet.
    cross_err = 0;
    applyStimulus(0, 8'h5A, 1'b0);
    applyStimulus(0, 8'hC3, 1'b1);
    applyStimulus(1, 8'h77, 1'b1);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hC3);
    if (CSUM_ON) exp_q.push_back(8'h99);
    exp_q.push_back(8'h77);
    if (CSUM_ON) exp_q.push_back(8'h77);
    n = exp_q.size();
    waitLine(n, 1500, "t3");
    checkLine("t3");
    checkOutput("t3_foreign_ready", cross_err, 0);
    checkGrants("t3", 2, 3'd0, 3'd1);

    // Requester 0 stalls between bytes; ownership is kept with no start pulses.
    s = start_cnt;
    applyStimulus(0, 8'h10, 1'b0);
    k = 0;
    while (!req_ready[0] && k < 200) begin
      @(negedge clk);
      k++;
    end
    checkOutput("t4_accept", 32'(k < 200), 32'd1);
    stall0 = 1'b1;
    applyStimulus(0, 8'h20, 1'b1);
    repeat (2) @(negedge clk);
    k = 0;
    while (!tx_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    checkOutput("t4_first_done", 32'(k < 200), 32'd1);
    win_starts = 0;
    win_rdy    = 0;
    win_idle   = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_start)     win_starts++;
      if (req_ready[0]) win_rdy++;
      if (!busy)        win_idle++;
    end
    checkOutput("t4_stall_starts", win_starts, 0);
    checkOutput("t4_stall_ready",  win_rdy,    0);
    checkOutput("t4_stall_busy_low", win_idle, 0);
    checkOutput("t4_stall_line", line_q.size(), 1);
    stall0 = 1'b0;
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h20);
    if (CSUM_ON) exp_q.push_back(8'h30);
    n = exp_q.size();
    waitLine(n, 1000, "t4");
    checkLine("t4");
    checkOutput("t4_starts", start_cnt - s, n);

    // uart_tx stays busy 10 extra cycles; tx_data must hold and starts stay one per byte.
    hold_extra = 10;
    stab_err   = 0;
    s = start_cnt;
    applyStimulus(0, 8'hE7, 1'b0);
    applyStimulus(0, 8'h81, 1'b1);
    exp_q.push_back(8'hE7);
    exp_q.push_back(8'h81);
    if (CSUM_ON) exp_q.push_back(8'h66);
    n = exp_q.size();
    waitLine(n, 1000, "t5");
    checkLine("t5");
    checkOutput("t5_starts", start_cnt - s, n);
    checkOutput("t5_tx_data_stable", stab_err, 0);
    hold_extra = 0;

    // Reset during the second byte's WAIT_DONE.
    s = start_cnt;
    applyStimulus(0, 8'h01, 1'b0);
    applyStimulus(0, 8'h02, 1'b0);
    applyStimulus(0, 8'h03, 1'b1);
    k = 0;
    while (start_cnt < s + 2 && k < 300) begin
      @(negedge clk);
      k++;
    end
    checkOutput("t6_second_start", 32'(k < 300), 32'd1);
    repeat (10) @(negedge clk);
    check_en = 1'b0;
    rst = 1'b1;
    q0.delete();
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t6_rst_busy",      32'(busy),      32'd0);
    checkOutput("t6_rst_tx_start",  32'(tx_start),  32'd0);
    checkOutput("t6_rst_tx_data",   32'(tx_data),   32'h00);
    checkOutput("t6_rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("t6_rst_grant_id",  32'(grant_id),  32'd0);
    s1 = start_cnt;
    applyStimulus(1, 8'h44, 1'b1);
    k = 0;
    while (!tx_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    checkOutput("t6_inflight_done", 32'(k < 100), 32'd1);
    @(negedge clk);
    checkOutput("t6_no_start_while_busy", start_cnt - s1, 0);
    line_q.delete();
    check_en = 1'b1;
    exp_q.push_back(8'h44);
    if (CSUM_ON) exp_q.push_back(8'h44);
    n = exp_q.size();
    waitLine(n, 1000, "t6");
    checkLine("t6");
    checkOutput("t6_starts", start_cnt - s1, n);
    checkOutput("overlap_starts", overlap_err, 0);
    checkOutput("foreign_ready_total", cross_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
